// File: rtl/cacheline_arbiter_if.sv
// One cache-line transaction port: request side (master) and memory/responder side (slave).
// Used for icache<->arbiter, dcache<->arbiter and arbiter<->pmem; icache never writes.
interface cacheline_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              resp;

  modport master (output read, write, address, wdata, input rdata, resp);
  modport slave  (input read, write, address, wdata, output rdata, resp);
endinterface

// File: rtl/cacheline_arbiter.sv
// Serialises icache/dcache line transactions onto the single pmem port, dcache first.
// Define CACHELINE_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests.
module cacheline_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_arbiter_if.slave  icache,
  cacheline_arbiter_if.slave  dcache,
  cacheline_arbiter_if.master pmem
);
  localparam int OFF_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t            state_reg, state_next;
  logic              i_req, d_req, d_first;
  logic [ADDR_W-1:0] line_mask;
  logic              unused_ok;

  assign line_mask = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  assign i_req     = icache.read;
  assign d_req     = dcache.read | dcache.write;
  assign unused_ok = ^{icache.write, icache.wdata};

  // Read data is broadcast; each cache qualifies it with its own resp.
  assign icache.rdata = pmem.rdata;
  assign dcache.rdata = pmem.rdata;

`ifdef CACHELINE_ARB_ROUND_ROBIN_EN
  logic prio_d_reg, prio_d_next;

  always_ff @(posedge clk) begin
    if (rst) prio_d_reg <= 1'b1;
    else     prio_d_reg <= prio_d_next;
  end

  // Pointer moves only on completion, to whichever cache was not just served.
  always_comb begin
    prio_d_next = prio_d_reg;
    if (pmem.resp && state_reg == SERVE_D)      prio_d_next = 1'b0;
    else if (pmem.resp && state_reg == SERVE_I) prio_d_next = 1'b1;
  end

  assign d_first = d_req && (prio_d_reg || !i_req);
`else
  assign d_first = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    pmem.read    = 1'b0;
    pmem.write   = 1'b0;
    pmem.address = '0;
    pmem.wdata   = '0;
    icache.resp  = 1'b0;
    dcache.resp  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (d_first)    state_next = SERVE_D;
        else if (i_req) state_next = SERVE_I;
      end
      SERVE_I: begin
        pmem.read    = icache.read;
        pmem.address = icache.address & line_mask;
        icache.resp  = pmem.resp;
        if (pmem.resp) state_next = IDLE;
      end
      SERVE_D: begin
        // A simultaneous read+write is treated as a writeback.
        pmem.read    = dcache.read & ~dcache.write;
        pmem.write   = dcache.write;
        pmem.address = dcache.address & line_mask;
        pmem.wdata   = dcache.wdata;
        dcache.resp  = pmem.resp;
        if (pmem.resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule
